// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a single shared hex decoder,
// frame-synchronous value loading, leading-zero blanking and frame-counted blinking.
module seg7_scan_ctrl #(
    parameter int PRESCALE     = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        load_valid,
    input  logic [15:0] load_value,
    output logic        load_ready,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [6:0]  seg_n,
    output logic [3:0]  dig_sel_n
);

    localparam int TW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int FW = 8;

    logic [TW-1:0] tick_reg, tick_next;
    logic [1:0]    slot_reg, slot_next;
    logic [FW-1:0] frame_reg, frame_next;
    logic          phase_reg, phase_next;
    logic [15:0]   disp_reg, disp_next;
    logic [15:0]   pend_reg, pend_next;
    logic          pend_full_reg, pend_full_next;
    logic [6:0]    seg_n_reg, seg_n_next;
    logic [3:0]    dig_sel_n_reg, dig_sel_n_next;

    logic          tick_tc;
    logic          frame_wrap;
    logic          load_accept;
    logic [3:0]    digits [4];
    logic [3:0]    lz_blank;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_out;
    logic          blank;

    assign tick_tc     = (tick_reg == TW'(PRESCALE - 1));
    assign frame_wrap  = tick_tc && (slot_reg == 2'd3);
    assign load_ready  = ~pend_full_reg;
    assign load_accept = load_valid && load_ready;

    // Digit i is a leading zero when it and every more-significant digit are zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digits[gi] = disp_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = blank_lz && (disp_reg[15:4*gi] == '0);
            end
        end
    endgenerate

    assign cur_digit = digits[slot_reg];

    always_comb begin
        dec_out = 7'h7F;
        case (cur_digit)
            4'h0: dec_out = 7'h40;
            4'h1: dec_out = 7'h79;
            4'h2: dec_out = 7'h24;
            4'h3: dec_out = 7'h30;
            4'h4: dec_out = 7'h19;
            4'h5: dec_out = 7'h12;
            4'h6: dec_out = 7'h02;
            4'h7: dec_out = 7'h78;
            4'h8: dec_out = 7'h00;
            4'h9: dec_out = 7'h18;
            4'hA: dec_out = 7'h08;
            4'hB: dec_out = 7'h03;
            4'hC: dec_out = 7'h46;
            4'hD: dec_out = 7'h21;
            4'hE: dec_out = 7'h06;
            4'hF: dec_out = 7'h0E;
            default: dec_out = 7'h7F;
        endcase
    end

    always_comb begin
        tick_next      = tick_reg + TW'(1);
        slot_next      = slot_reg;
        frame_next     = frame_reg;
        phase_next     = phase_reg;
        disp_next      = disp_reg;
        pend_next      = pend_reg;
        pend_full_next = pend_full_reg;

        if (tick_tc) begin
            tick_next = '0;
            slot_next = slot_reg + 2'd1;
        end

        if (frame_wrap) begin
            if (pend_full_reg) begin
                disp_next      = pend_reg;
                pend_full_next = 1'b0;
            end
            if (frame_reg == FW'(BLINK_FRAMES - 1)) begin
                frame_next = '0;
                phase_next = ~phase_reg;
            end else begin
                frame_next = frame_reg + FW'(1);
            end
        end

        // Acceptance implies pending was empty, so it never collides with a commit;
        // a load on the wrap edge therefore waits for the next wrap.
        if (load_accept) begin
            pend_next      = load_value;
            pend_full_next = 1'b1;
        end
    end

    always_comb begin
        blank          = (blink_en && phase_reg) || lz_blank[slot_reg];
        seg_n_next     = blank ? 7'h7F : dec_out;
        // All digits off on the first cycle of a slot to avoid ghosting.
        dig_sel_n_next = (tick_reg == '0) ? 4'hF : ~(4'b0001 << slot_reg);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tick_reg      <= '0;
            slot_reg      <= '0;
            frame_reg     <= '0;
            phase_reg     <= 1'b0;
            disp_reg      <= '0;
            pend_reg      <= '0;
            pend_full_reg <= 1'b0;
            seg_n_reg     <= 7'h7F;
            dig_sel_n_reg <= 4'hF;
        end else begin
            tick_reg      <= tick_next;
            slot_reg      <= slot_next;
            frame_reg     <= frame_next;
            phase_reg     <= phase_next;
            disp_reg      <= disp_next;
            pend_reg      <= pend_next;
            pend_full_reg <= pend_full_next;
            seg_n_reg     <= seg_n_next;
            dig_sel_n_reg <= dig_sel_n_next;
        end
    end

    assign seg_n     = seg_n_reg;
    assign dig_sel_n = dig_sel_n_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a driver predicts each cycle's outputs from
// cycle-index arithmetic and a frame-level load model; a monitor pops and compares.
module tb_seg7_scan_ctrl;

    localparam int P  = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic        load_ready;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [6:0]  seg_n;
    logic [3:0]  dig_sel_n;

    seg7_scan_ctrl #(.PRESCALE(P), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .seg_n      (seg_n),
        .dig_sel_n  (dig_sel_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       rdy;
        int         k;
    } exp_t;

    exp_t q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: edge index since reset release, plus frame-level load model.
    int          k = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_pfull = 1'b0;
    logic        cur_blz = 1'b0;
    logic        cur_ben = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called at a negedge: drive inputs for the coming posedge, predict, then wait one cycle.
    task automatic drive(input logic v, input logic [15:0] val);
        int          tk, sl, fr, ph;
        logic [15:0] sh;
        logic [3:0]  onehot;
        logic        blanked;
        bit          wrap, acc;
        exp_t        e;
        load_valid = v;
        load_value = val;
        blank_lz   = cur_blz;
        blink_en   = cur_ben;

        tk = k % P;
        sl = (k / P) % 4;
        fr = k / (4 * P);
        ph = (fr / BF) % 2;
        onehot = 4'b0001;
        onehot = onehot << sl;
        sh = m_disp >> (4 * sl);
        blanked = (cur_ben && ph == 1) || (cur_blz && sl > 0 && sh == 16'h0);
        e.seg = blanked ? 7'h7F : seg_tab[sh[3:0]];
        e.dig = (tk == 0) ? 4'hF : ~onehot;
        e.k   = k;

        wrap = (k % (4 * P)) == (4 * P - 1);
        acc  = v && !m_pfull;
        if (wrap && m_pfull) begin
            m_disp  = m_pend;
            m_pfull = 1'b0;
        end
        if (acc) begin
            m_pend  = val;
            m_pfull = 1'b1;
            $display("load accepted value=%h edge=%0d frame=%0d slot=%0d", val, k, fr, sl);
        end
        e.rdy = !m_pfull;
        q.push_back(e);
        k++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom));
    endtask

    task automatic idle_until_phase(input int pos);
        int guard = 0;
        while ((k % (4 * P)) != pos && guard < 64) begin
            drive(1'b0, 16'h0);
            guard++;
        end
    endtask

    task automatic release_reset();
        resetN  = 1'b1;
        k       = 0;
        m_disp  = 16'h0;
        m_pend  = 16'h0;
        m_pfull = 1'b0;
    endtask

    // Monitor: compare whatever the driver predicted for the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("seg_n@%0d", e.k), 32'(seg_n), 32'(e.seg));
                check($sformatf("dig_sel_n@%0d", e.k), 32'(dig_sel_n), 32'(e.dig));
                check($sformatf("load_ready@%0d", e.k), 32'(load_ready), 32'(e.rdy));
            end
        end
    end

    initial begin
        #2 resetN = 1'b0;
        #1;
        check("reset seg_n", 32'(seg_n), 32'h7F);
        check("reset dig_sel_n", 32'(dig_sel_n), 32'hF);
        check("reset load_ready", 32'(load_ready), 32'h1);
        repeat (2) @(negedge clk);
        release_reset();

        // Basic scan of 1234.
        drive(1'b1, 16'h1234);
        idle(3 * 4 * P);

        // Mid-frame load followed by held valid with 0000.
        idle_until_phase(6);
        drive(1'b1, 16'hA5C3);
        for (int i = 0; i < 30; i++) drive(1'b1, 16'h0000);
        idle(20);

        // Load exactly on the frame-wrap edge.
        idle(4 * P);
        idle_until_phase(4 * P - 1);
        drive(1'b1, 16'hBEEF);
        idle(3 * 4 * P);

        // Leading-zero blanking.
        cur_blz = 1'b1;
        drive(1'b1, 16'h0050);
        idle(3 * 4 * P);
        drive(1'b1, 16'h0000);
        idle(3 * 4 * P);
        cur_blz = 1'b0;

        // Blink with 8888.
        cur_ben = 1'b1;
        drive(1'b1, 16'h8888);
        idle(6 * 4 * P);
        cur_ben = 1'b0;

        // Randomized traffic including small values for blanking coverage.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] val;
            val = 16'($urandom);
            case ($urandom_range(0, 3))
                0: val = val & 16'h000F;
                1: val = val & 16'h00FF;
                2: val = val & 16'h0FFF;
                default: ;
            endcase
            if ($urandom_range(0, 31) == 0) cur_blz = ~cur_blz;
            if ($urandom_range(0, 31) == 0) cur_ben = ~cur_ben;
            drive($urandom_range(0, 3) == 0, val);
        end
        cur_blz = 1'b0;
        cur_ben = 1'b0;

        // Asynchronous reset while a load is pending.
        idle(4 * P);
        idle_until_phase(5);
        drive(1'b1, 16'h9999);
        idle(2);
        #2 resetN = 1'b0;
        #1;
        check("async seg_n", 32'(seg_n), 32'h7F);
        check("async dig_sel_n", 32'(dig_sel_n), 32'hF);
        check("async load_ready", 32'(load_ready), 32'h1);
        repeat (2) begin
            @(negedge clk);
            check("held seg_n", 32'(seg_n), 32'h7F);
            check("held dig_sel_n", 32'(dig_sel_n), 32'hF);
        end
        release_reset();
        idle(3 * 4 * P);

        @(posedge clk);
        #2;
        check("queue drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
